// File: rtl/arm7tdmi_pkg.sv
// Shared types for the ARM7TDMI memory subsystem: controller state encoding,
// wait-state ceiling and saturating-counter helper.
package arm7tdmi_pkg;

  typedef enum logic [2:0] {
    MEM_IDLE,
    MEM_WAIT,
    MEM_ACCESS,
    MEM_DONE,
    MEM_ERR
  } mem_ctrl_state_t;

  localparam int MEM_MAX_WAIT = 15;
  localparam int MEM_WCNT_W   = $clog2(MEM_MAX_WAIT + 1);
  localparam int MEM_PERF_CNT = 3;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/arm_mem_perf.sv
// Bank of saturating 32-bit event counters; one counter per inc bit.
module arm_mem_perf
  import arm7tdmi_pkg::*;
#(
  parameter int NUM_CNT = MEM_PERF_CNT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CNT-1:0]           inc,
  output logic [NUM_CNT-1:0][31:0]     cnt
);

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    // count events, sticking at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      cnt[g] <= '0;
      else if (inc[g]) cnt[g] <= sat_inc(cnt[g]);
    end
  end

endmodule

// File: rtl/arm_mem_ctrl.sv
// Wait-state memory controller between the ARM7TDMI memory port and a
// single-port synchronous SRAM with 1-cycle read latency.
// Optional: ARM_MEM_PERF_EN adds perf_reads/perf_writes/perf_waits counters.
module arm_mem_ctrl
  import arm7tdmi_pkg::*;
#(
  parameter int MEM_BYTES   = 4096,
  parameter int WAIT_STATES = 2,
  parameter int AW          = $clog2(MEM_BYTES) - 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   mem_addr,
  input  logic [31:0]   mem_wdata,
  input  logic          mem_we,
  input  logic          mem_re,
  input  logic [3:0]    mem_be,
  output logic [31:0]   mem_rdata,
  output logic          mem_ready,
  output logic          mem_abort,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  output logic [3:0]    sram_be,
  output logic          sram_ce,
  output logic          sram_we,
  input  logic [31:0]   sram_rdata
`ifdef ARM_MEM_PERF_EN
  ,
  output logic [31:0]   perf_reads,
  output logic [31:0]   perf_writes,
  output logic [31:0]   perf_waits
`endif
);

  localparam logic [MEM_WCNT_W-1:0] WS_LOAD =
    (WAIT_STATES == 0) ? '0 : MEM_WCNT_W'(WAIT_STATES - 1);

  mem_ctrl_state_t       state;
  logic [MEM_WCNT_W-1:0] wcnt;
  logic [AW-1:0]         lat_addr;
  logic [31:0]           lat_wdata;
  logic [3:0]            lat_be;
  logic                  lat_wr;
  logic [31:0]           rdata_q;

  logic                  req, in_range;
  logic [AW-1:0]         acc_addr;
  logic [31:0]           acc_wdata;
  logic [3:0]            acc_be;
  logic                  acc_wr;

  assign req      = mem_re | mem_we;
  assign in_range = (mem_addr < 32'(MEM_BYTES));

  // SRAM strobe source: latched request when leaving WAIT, live core inputs
  // when a zero-wait accept jumps straight to ACCESS
  always_comb begin
    acc_wr    = mem_we;
    acc_addr  = mem_addr[AW+1:2];
    acc_wdata = mem_wdata;
    acc_be    = mem_be;
    if (state == MEM_WAIT) begin
      acc_wr    = lat_wr;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_be    = lat_be;
    end
  end

  // controller FSM with registered SRAM strobes (pulsed only in ACCESS)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= MEM_IDLE;
      wcnt       <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      lat_wr     <= 1'b0;
      rdata_q    <= '0;
      sram_ce    <= 1'b0;
      sram_we    <= 1'b0;
      sram_be    <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      sram_ce    <= 1'b0;
      sram_we    <= 1'b0;
      sram_be    <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      case (state)
        MEM_IDLE, MEM_DONE, MEM_ERR: begin
          if (state == MEM_DONE && !lat_wr) rdata_q <= sram_rdata;
          if (!req) begin
            state <= MEM_IDLE;
          end else if (!in_range) begin
            state <= MEM_ERR;
          end else begin
            lat_addr  <= mem_addr[AW+1:2];
            lat_wdata <= mem_wdata;
            lat_be    <= mem_be;
            lat_wr    <= mem_we;
            wcnt      <= WS_LOAD;
            state     <= (WAIT_STATES == 0) ? MEM_ACCESS : MEM_WAIT;
            if (WAIT_STATES == 0) begin
              sram_ce    <= 1'b1;
              sram_we    <= acc_wr;
              sram_be    <= acc_wr ? acc_be : 4'b0000;
              sram_addr  <= acc_addr;
              sram_wdata <= acc_wr ? acc_wdata : 32'h0;
            end
          end
        end
        MEM_WAIT: begin
          if (wcnt == '0) begin
            state      <= MEM_ACCESS;
            sram_ce    <= 1'b1;
            sram_we    <= acc_wr;
            sram_be    <= acc_wr ? acc_be : 4'b0000;
            sram_addr  <= acc_addr;
            sram_wdata <= acc_wr ? acc_wdata : 32'h0;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        MEM_ACCESS: state <= MEM_DONE;
        default:    state <= MEM_IDLE;
      endcase
    end
  end

  assign mem_ready = (state == MEM_DONE) || (state == MEM_ERR) ||
                     (state == MEM_IDLE && !req);
  assign mem_abort = (state == MEM_ERR);

  // read data: SRAM bypass in a read DONE, zero on abort, else held value
  always_comb begin
    mem_rdata = rdata_q;
    if (state == MEM_DONE && !lat_wr) mem_rdata = sram_rdata;
    else if (state == MEM_ERR)        mem_rdata = 32'h0;
  end

`ifdef ARM_MEM_PERF_EN
  logic [MEM_PERF_CNT-1:0]       perf_inc;
  logic [MEM_PERF_CNT-1:0][31:0] perf_cnt;

  assign perf_inc = {state == MEM_WAIT,
                     state == MEM_DONE && lat_wr,
                     state == MEM_DONE && !lat_wr};

  arm_mem_perf #(.NUM_CNT(MEM_PERF_CNT)) u_perf (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (perf_inc),
    .cnt   (perf_cnt)
  );

  assign perf_reads  = perf_cnt[0];
  assign perf_writes = perf_cnt[1];
  assign perf_waits  = perf_cnt[2];
`endif

endmodule

// File: tb/tb_arm_mem_ctrl.sv
// Randomized bench for arm_mem_ctrl: behavioural SRAM plus a transaction-level
// reference model (word array, expected latency/abort/data per transfer).
module tb_arm_mem_ctrl;

  localparam int MEM_BYTES = 4096;
  localparam int WS        = 2;
  localparam int AW        = 10;
  localparam int WORDS     = MEM_BYTES / 4;

  logic          clk, rst_n;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata, sram_wdata, sram_rdata;
  logic          mem_we, mem_re, mem_ready, mem_abort, sram_ce, sram_we;
  logic [3:0]    mem_be, sram_be;
  logic [AW-1:0] sram_addr;
`ifdef ARM_MEM_PERF_EN
  logic [31:0]   perf_reads, perf_writes, perf_waits;
`endif

  arm_mem_ctrl #(.MEM_BYTES(MEM_BYTES), .WAIT_STATES(WS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_be     (mem_be),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .mem_abort  (mem_abort),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_be    (sram_be),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_rdata (sram_rdata)
`ifdef ARM_MEM_PERF_EN
    ,
    .perf_reads  (perf_reads),
    .perf_writes (perf_writes),
    .perf_waits  (perf_waits)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural SRAM, loaded from init_mem on the first edge
  logic [31:0] init_mem [0:WORDS-1];
  logic [31:0] sram     [0:WORDS-1];
  bit          loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < WORDS; i++) sram[i] <= init_mem[i];
      loaded <= 1'b1;
    end else if (sram_ce) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) sram[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= sram[sram_addr];
      end
    end
  end

  // reference model state
  logic [31:0] ref_mem [0:WORDS-1];
  logic [31:0] last_rd;
  int          ref_rd, ref_wr, ref_wait;
  bit          at_idle;
  int          n_chk, n_pass;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // issue one request now, follow it to mem_ready, compare with the model;
  // returns on the falling edge inside the completing cycle
  task automatic xfer(input bit wr, input bit rd, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] be);
    int cyc, we_cnt, ce_cnt, w;
    bit is_wr, inr;
    logic [31:0] exp_rd;
    mem_we = wr; mem_re = rd; mem_addr = addr; mem_wdata = wd; mem_be = be;
    if (at_idle) begin
      #1 chk("rdy_accept", mem_ready, 0);
    end
    at_idle = 1'b0;
    cyc = 0; we_cnt = 0; ce_cnt = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (sram_we) we_cnt++;
      if (sram_ce) ce_cnt++;
    end while (!mem_ready && cyc < 40);

    is_wr = wr;
    inr   = (addr < MEM_BYTES);
    w     = int'(addr[11:2]);
    if (!inr) begin
      chk("err_lat",   cyc,       1);
      chk("err_abort", mem_abort, 1);
      chk("err_rdata", mem_rdata, 0);
      chk("err_ce",    ce_cnt,    0);
    end else begin
      if (is_wr) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
        exp_rd = last_rd;
        ref_wr++;
      end else begin
        exp_rd  = ref_mem[w];
        last_rd = exp_rd;
        ref_rd++;
      end
      ref_wait += WS;
      chk("lat",    cyc,       WS + 2);
      chk("abort",  mem_abort, 0);
      chk("rdata",  mem_rdata, exp_rd);
      chk("we_cnt", we_cnt,    is_wr ? 1 : 0);
      chk("ce_cnt", ce_cnt,    1);
      if (is_wr) chk("sram_word", sram[w], ref_mem[w]);
    end
    @(negedge clk);
  endtask

  // drop the request and sit idle; ready must be high and rdata held
  task automatic idle(input int n);
    mem_we = 1'b0; mem_re = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_ready", mem_ready, 1);
      chk("idle_rdata", mem_rdata, last_rd);
    end
    at_idle = 1'b1;
  endtask

  initial begin
    int k;
    logic [31:0] a;
    n_chk = 0; n_pass = 0;
    ref_rd = 0; ref_wr = 0; ref_wait = 0; last_rd = 0;
    for (int i = 0; i < WORDS; i++) init_mem[i] = $urandom;
    init_mem[3]  = 32'hE081_3002;
    init_mem[5]  = 32'h1122_3344;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = init_mem[i];
    rst_n = 1'b0; mem_we = 0; mem_re = 0; mem_addr = 0; mem_wdata = 0; mem_be = 0;
    at_idle = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_ready", mem_ready, 1);
    chk("rst_abort", mem_abort, 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_ce",    sram_ce,   0);
    chk("rst_we",    sram_we,   0);
    chk("rst_be",    sram_be,   0);
    chk("rst_addr",  sram_addr, 0);
    chk("rst_wdata", sram_wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed: read word 3, data held after re drops
    xfer(0, 1, 32'h0C, 0, 4'hF);
    chk("rd3_val", mem_rdata, 32'hE081_3002);
    idle(2);
    // directed: byte-lane write to word 5
    xfer(1, 0, 32'h14, 32'hAABB_CCDD, 4'b0101);
    idle(1);
    chk("bytewr", sram[5], 32'h11BB_33DD);
    // directed: out-of-range read
    xfer(0, 1, 32'h1000, 0, 4'hF);
    idle(1);
    // directed: back-to-back write then read of 0x20
    xfer(1, 0, 32'h20, 32'h5, 4'hF);
    xfer(0, 1, 32'h20, 0, 4'hF);
    chk("b2b_val", mem_rdata, 32'h5);
    idle(1);
    // directed: write with no lanes enabled leaves the word alone
    xfer(1, 0, 32'h40, 32'hFFFF_FFFF, 4'b0000);
    idle(1);
    chk("be0_word", sram[16], init_mem[16]);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h1000 + (a & 32'h0000_FFFF);
      else                           a = a & 32'h0000_0FFF;
      k = $urandom_range(0, 2);
      xfer(k != 0, k != 1, a, $urandom, 4'($urandom));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(1);

`ifdef ARM_MEM_PERF_EN
    chk("perf_reads",  perf_reads,  ref_rd);
    chk("perf_writes", perf_writes, ref_wr);
    chk("perf_waits",  perf_waits,  ref_wait);
`endif

    // reset during the ACCESS cycle of a write to word 12
    mem_we = 1'b1; mem_addr = 32'h30; mem_wdata = 32'hDEAD_BEEF; mem_be = 4'hF;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!sram_we && k < 20);
    chk("rst_mid_seen", sram_we, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_we", sram_we, 0);
    chk("rst_mid_ce", sram_ce, 0);
    mem_we = 1'b0;
    #1;
    chk("rst_mid_ready", mem_ready, 1);
    chk("rst_mid_rdata", mem_rdata, 0);
    last_rd = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_word", sram[12], ref_mem[12]);
    at_idle = 1'b1;
    xfer(0, 1, 32'h30, 0, 4'hF);
    idle(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/arm_mem_ctrl.md
Name: arm_mem_ctrl

Overview:
- Memory controller between the arm7tdmi_top memory port (mem_addr/mem_wdata/mem_rdata/mem_we/mem_re/mem_be/mem_ready) and a single-port synchronous SRAM (1-cycle read latency).
- Inserts programmable wait states and converts core byte enables into SRAM lane writes.
- Generates mem_ready and flags out-of-range accesses with a data abort.
- Replaces the zero-wait, always-ready memory model currently used in simulation.

Parameters:
- MEM_BYTES, 4096, SRAM size in bytes; power of two, >= 8.
- WAIT_STATES, 2, extra cycles inserted before each SRAM access; range 0..15.
- AW, $clog2(MEM_BYTES)-2, SRAM word-address width (derived; do not override).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_addr  in  32  core byte address; bits [1:0] ignored.
- mem_wdata  in  32  core write data.
- mem_we  in  1  write request.
- mem_re  in  1  read request.
- mem_be  in  4  byte-lane enables; bit n = bits [8n+7:8n].
- mem_rdata  out  32  read data.
- mem_ready  out  1  transfer complete / controller idle.
- mem_abort  out  1  out-of-range access; valid only with mem_ready.
- sram_addr  out  AW  SRAM word address.
- sram_wdata  out  32  SRAM write data.
- sram_be  out  4  SRAM lane write enables.
- sram_ce  out  1  SRAM chip enable.
- sram_we  out  1  SRAM write strobe (with sram_ce).
- sram_rdata  in  32  SRAM read data; valid the cycle after a read ACCESS.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE; mem_rdata=0; mem_abort=0; sram_ce=0; sram_we=0; sram_be=0; sram_addr=0; sram_wdata=0; wait counter=0.
- Request definition: req = mem_re | mem_we. If both are high, the access is a write.
- Core contract: the core holds addr, wdata, be, we and re stable from request until the cycle mem_ready=1. On accept, the controller latches addr, wdata, be and the write flag; later changes on the core inputs are ignored until DONE/ERR.
- States: IDLE, WAIT, ACCESS, DONE, ERR.
- IDLE:
  - mem_ready = ~req.
  - req with mem_addr >= MEM_BYTES -> ERR.
  - Otherwise -> WAIT, counter loaded with WAIT_STATES-1; if WAIT_STATES==0 -> ACCESS directly.
- WAIT: counter decrements each cycle; at 0 -> ACCESS. mem_ready=0.
- ACCESS:
  - sram_ce=1 and sram_addr = latched addr[AW+1:2].
  - Write: sram_we=1, sram_be = latched be, sram_wdata = latched wdata.
  - Read: sram_we=0, sram_be=0.
  - mem_ready=0. Next state is DONE.
- DONE:
  - mem_ready=1, mem_abort=0.
  - Read: mem_rdata = sram_rdata combinationally in this cycle, and sram_rdata is also registered. After DONE, mem_rdata holds the registered value until the next read completes. Writes do not change mem_rdata.
  - Next: req ? (accept as in IDLE, back-to-back) : IDLE.
- ERR:
  - mem_ready=1, mem_abort=1, mem_rdata=0. No SRAM strobe is issued.
  - Next state is as in DONE.
- Latency: from the accept cycle, mem_ready rises after WAIT_STATES+2 cycles (WAIT_STATES=2 gives 4). Error latency is 1 cycle.
- Edge cases:
  - Write with mem_be=4'b0000: the full sequence runs and sram_we=1 with sram_be=0, so no byte changes.
  - Counter is sized for a maximum of 15 and never wraps.
- Reset mid-operation: asynchronous return to IDLE. sram_ce and sram_we drop immediately, so no partial write is committed after reset assertion. A pending transfer is discarded.

Optional Feature:
- ARM_MEM_PERF_EN defined: adds outputs perf_reads, perf_writes and perf_waits (32 bits each).
  - perf_reads and perf_writes increment on DONE for the matching access type.
  - perf_waits increments in every WAIT cycle.
  - All three saturate at 32'hFFFFFFFF and reset to 0.
- ARM_MEM_PERF_EN undefined: these ports and counters are absent. Base behaviour is identical.

Decomposition:
- arm7tdmi_pkg gains:
  - typedef enum logic [2:0] mem_ctrl_state_t {IDLE, WAIT, ACCESS, DONE, ERR}; prefix the enumerators (MEM_IDLE etc.) if they collide with core-state names.
  - localparam MEM_MAX_WAIT = 15.
- Sub-module arm_mem_perf holds the saturating counters. It is instantiated only under ARM_MEM_PERF_EN.

Test Plan:
- Read, WAIT_STATES=2, SRAM word 3 = 32'hE0813002, mem_re=1 at addr 0x0C -> mem_ready low for 4 cycles, then high 1 cycle; mem_rdata=32'hE0813002, and is held after re drops.
- Byte write: word 5 = 32'h11223344, write 32'hAABBCCDD with be=4'b0101 to 0x14 -> word 5 = 32'h11BB33DD; sram_we high exactly 1 cycle.
- Out of range: read at 0x1000 with MEM_BYTES=4096 -> next cycle mem_ready=1, mem_abort=1, mem_rdata=0; sram_ce never asserted.
- Back-to-back: write 0x20 = 32'h5, then read 0x20 issued in the DONE cycle -> read returns 32'h5 with no idle cycle between transfers.
- Reset mid-op: rst_n low during ACCESS of a write to 0x30 -> sram_we=0 immediately, state IDLE, word 12 unchanged.
- ARM_MEM_PERF_EN, WAIT_STATES=2: 3 reads + 2 writes -> perf_reads=3, perf_writes=2, perf_waits=10.
